// File: rtl/sr_chk_pkg.sv
// Shared types and constants for the SR flip-flop checker.
package sr_chk_pkg;

    // Checker FSM states; code 3 is unused and recovers to UNKNOWN
    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        TRACK   = 2'd1,
        INVALID = 2'd2
    } state_e;

    // {s, r} stimulus encodings
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_RST  = 2'b01;
    localparam logic [1:0] SR_BAD  = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count up on inc, hold once every bit is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (inc && (r_count != {W{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign count = r_count;

endmodule

// File: rtl/sr_ff_checker.sv
// Reference-model checker for a posedge SR flip-flop: predicts q from the
// sampled s/r, compares one cycle later, and flags q / qb mismatches.
module sr_ff_checker
    import sr_chk_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             qb,
    output logic             err,
    output logic             err_q,
    output logic             err_qb,
    output logic [CNT_W-1:0] err_count,
    output logic             invalid_seen,
    output logic [1:0]       state
);

    state_e     r_state;
    logic       r_exp_q;
    logic       r_err;
    logic       r_err_q;
    logic       r_err_qb;
    logic       r_invalid_seen;
    logic [1:0] w_sr;
    logic       w_track;
    logic       w_q_mis;
    logic       w_qb_mis;
    logic       w_legal;

    assign w_sr    = {s, r};
    assign w_track = (r_state == TRACK);
    assign w_legal = (r_state == UNKNOWN) || (r_state == TRACK) || (r_state == INVALID);

    // Checks only run while the model is known-good; the state seen here is
    // the one produced by the previous edge, giving the one-cycle latency.
    assign w_q_mis  = en && w_track && (q != r_exp_q);
    assign w_qb_mis = en && w_track && (qb == q);

    // Model of the flip-flop plus the tracking FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= UNKNOWN;
            r_exp_q <= 1'b0;
        end else if (!w_legal) begin
            r_state <= UNKNOWN;
        end else if (en) begin
            case (w_sr)
                SR_SET: begin
                    r_state <= TRACK;
                    r_exp_q <= 1'b1;
                end
                SR_RST: begin
                    r_state <= TRACK;
                    r_exp_q <= 1'b0;
                end
                SR_BAD:  r_state <= INVALID;
                SR_HOLD: ;
                default: ;
            endcase
        end
    end

    // Registered mismatch flags and the sticky illegal-input flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err          <= 1'b0;
            r_err_q        <= 1'b0;
            r_err_qb       <= 1'b0;
            r_invalid_seen <= 1'b0;
        end else begin
            r_err    <= w_q_mis | w_qb_mis;
            r_err_q  <= w_q_mis;
            r_err_qb <= w_qb_mis;
            if (en && (w_sr == SR_BAD))
                r_invalid_seen <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_q_mis | w_qb_mis),
        .count (err_count)
    );

    assign err          = r_err;
    assign err_q        = r_err_q;
    assign err_qb       = r_err_qb;
    assign invalid_seen = r_invalid_seen;
    assign state        = r_state;

endmodule
